// File: rtl/od_line_pkg.sv
// Shared types and default timing for the open-drain line receiver.
package od_line_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOW      = 2'd1,
        ST_RST_HOLD = 2'd2
    } state_e;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_T_MIN  = 4;
    localparam int unsigned DEF_T_THR  = 20;
    localparam int unsigned DEF_T_RST  = 100;
    localparam int unsigned DEF_T_IDLE = 200;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        if (max_val < 1) begin
            cnt_w = 1;
        end else begin
            cnt_w = $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/od_line_sync.sv
// Two-flop synchronizer for the asynchronous open-drain wire; idles high.
module od_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic d_sync
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = d_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign d_sync = sync2_q;

endmodule

// File: rtl/od_line_rx.sv
// Open-drain line receiver: measures low-pulse widths, decodes bits, bus
// resets and glitches, and assembles LSB-first words onto a valid/ready port.
module od_line_rx
    import od_line_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned T_MIN  = DEF_T_MIN,
    parameter int unsigned T_THR  = DEF_T_THR,
    parameter int unsigned T_RST  = DEF_T_RST,
    parameter int unsigned T_IDLE = DEF_T_IDLE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              bus_rst,
    output logic              glitch,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned LO_W   = cnt_w(T_RST);
    localparam int unsigned IDLE_W = cnt_w(T_IDLE);
    localparam int unsigned BC_W   = cnt_w(DATA_W - 1);

    localparam logic [LO_W-1:0]   LO_ONE    = LO_W'(1);
    localparam logic [LO_W-1:0]   LO_MIN    = LO_W'(T_MIN);
    localparam logic [LO_W-1:0]   LO_THR    = LO_W'(T_THR);
    localparam logic [LO_W-1:0]   LO_RST    = LO_W'(T_RST);
    localparam logic [LO_W-1:0]   LO_RST_M1 = LO_W'(T_RST - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(T_IDLE - 1);
    localparam logic [BC_W-1:0]   BIT_ONE   = BC_W'(1);
    localparam logic [BC_W-1:0]   BIT_LAST  = BC_W'(DATA_W - 1);

    logic s;

    state_e              state_q,     state_d;
    logic [LO_W-1:0]     lo_cnt_q,    lo_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q,  idle_cnt_d;
    logic [BC_W-1:0]     bit_cnt_q,   bit_cnt_d;
    logic [DATA_W-2:0]   shreg_q,     shreg_d;
    logic [DATA_W-1:0]   rx_data_q,   rx_data_d;
    logic                rx_valid_q,  rx_valid_d;
    logic                bus_rst_q,   bus_rst_d;
    logic                glitch_q,    glitch_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q,   overrun_d;

    logic                bit_valid;
    logic                bit_val;
    logic [DATA_W-1:0]   word;

    od_line_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_in   (line_in),
        .d_sync (s)
    );

    always_comb begin
        state_d     = state_q;
        lo_cnt_d    = lo_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q && !rx_ready;
        bus_rst_d   = 1'b0;
        glitch_d    = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        bit_valid   = 1'b0;
        bit_val     = 1'b0;
        word        = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (!s) begin
                    state_d    = ST_LOW;
                    lo_cnt_d   = LO_ONE;
                    idle_cnt_d = '0;
                end else if (bit_cnt_q != '0) begin
                    // Partial word pending: abandon it after T_IDLE high cycles.
                    if (idle_cnt_q == IDLE_LAST) begin
                        frame_err_d = 1'b1;
                        bit_cnt_d   = '0;
                        idle_cnt_d  = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_ONE;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end

            ST_LOW: begin
                if (!s) begin
                    if (lo_cnt_q == LO_RST_M1) begin
                        lo_cnt_d  = LO_RST;
                        bus_rst_d = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_RST_HOLD;
                    end else begin
                        lo_cnt_d = lo_cnt_q + LO_ONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                    if (lo_cnt_q < LO_MIN) begin
                        glitch_d = 1'b1;
                    end else begin
                        bit_valid = 1'b1;
                        bit_val   = (lo_cnt_q < LO_THR);
                    end
                end
            end

            ST_RST_HOLD: begin
                if (s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // New bit enters at the MSB so the first bit lands in bit 0 of the word.
        if (bit_valid) begin
            word    = {bit_val, shreg_q};
            shreg_d = word[DATA_W-1:1];
            if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_d = '0;
                if (!rx_valid_q || rx_ready) begin
                    rx_data_d  = word;
                    rx_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + BIT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lo_cnt_q    <= '0;
            idle_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            bus_rst_q   <= 1'b0;
            glitch_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_cnt_q    <= lo_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            bus_rst_q   <= bus_rst_d;
            glitch_q    <= glitch_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign bus_rst   = bus_rst_q;
    assign glitch    = glitch_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_od_line_rx.sv
// Scoreboard bench for od_line_rx: a pulse-width model predicts words and
// events, a negedge monitor compares whatever the receiver presents.
module tb_od_line_rx;

    localparam int unsigned DW    = 8;
    localparam int unsigned TMIN  = 4;
    localparam int unsigned TTHR  = 20;
    localparam int unsigned TRST  = 100;
    localparam int unsigned TIDLE = 200;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          line_in  = 1'b1;
    logic          rx_ready = 1'b1;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          bus_rst;
    logic          glitch;
    logic          frame_err;
    logic          overrun;

    od_line_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_in   (line_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .bus_rst   (bus_rst),
        .glitch    (glitch),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   rise;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned bus_q[$];

    int checks = 0;
    int errors = 0;

    int exp_glitch = 0, exp_bus = 0, exp_frame = 0, exp_ovr = 0;
    int got_glitch = 0, got_bus = 0, got_frame = 0, got_ovr = 0;

    // Reference model: bits received so far in the current word.
    logic        mbits[DW];
    int unsigned nbits = 0;
    bit          held  = 1'b0;

    function automatic void check(string name, longint unsigned act, longint unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void fail_now(string name, longint unsigned act, longint unsigned req);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    endfunction

    // Monitor
    logic          prev_valid = 1'b0;
    logic          prev_acc   = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (glitch)    got_glitch++;
            if (frame_err) got_frame++;
            if (overrun)   got_ovr++;
            if (bus_rst) begin
                got_bus++;
                if (bus_q.size() == 0) fail_now("bus_rst_unexpected", cyc, 0);
                else check("bus_rst_cycle", cyc, bus_q.pop_front());
            end
            if (rx_valid && !prev_valid) begin
                if (exp_q.size() == 0) fail_now("word_unexpected", rx_data, 0);
                else check("valid_latency", cyc, exp_q[0].rise);
            end
            if (rx_valid && prev_valid && !prev_acc)
                check("data_stable", rx_data, prev_data);
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("word_unexpected", rx_data, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rx_data", rx_data, e.data);
                end
            end
            prev_valid = rx_valid;
            prev_data  = rx_data;
            prev_acc   = rx_valid && rx_ready;
        end
    end

    function automatic void model_bit(logic b, int unsigned rise_c);
        logic [DW-1:0] w;
        mbits[nbits] = b;
        nbits++;
        if (nbits == DW) begin
            nbits = 0;
            for (int i = 0; i < DW; i++) w[i] = mbits[i];
            if (held) begin
                exp_ovr++;
            end else begin
                exp_q.push_back('{data: w, rise: rise_c + 3});
                if (!rx_ready) held = 1'b1;
            end
        end
    endfunction

    // One low pulse of w cycles followed by gap high cycles (gap >= 2).
    task automatic send_pulse(int unsigned w, int unsigned gap);
        int unsigned fall_c;
        @(negedge clk);
        line_in = 1'b0;
        fall_c  = cyc;
        if (w >= TRST) begin
            bus_q.push_back(fall_c + 2 + TRST);
            exp_bus++;
            nbits = 0;
        end
        repeat (w) @(negedge clk);
        line_in = 1'b1;
        if (w < TRST) begin
            if (w < TMIN) exp_glitch++;
            else model_bit(w < TTHR, cyc);
        end
        if (gap > TIDLE && nbits > 0) begin
            exp_frame++;
            nbits = 0;
        end
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic send_bits(logic [DW-1:0] v, int unsigned n, int unsigned w1, int unsigned w0);
        for (int unsigned i = 0; i < n; i++) begin
            logic [DW-1:0] t;
            t = v >> i;
            send_pulse(t[0] ? w1 : w0, 30);
        end
    endtask

    task automatic check_counts(string tag);
        repeat (10) @(negedge clk);
        check({tag, "_glitch_cnt"}, got_glitch, exp_glitch);
        check({tag, "_bus_rst_cnt"}, got_bus, exp_bus);
        check({tag, "_frame_err_cnt"}, got_frame, exp_frame);
        check({tag, "_overrun_cnt"}, got_ovr, exp_ovr);
        check({tag, "_words_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check("reset_outputs", {rx_data, rx_valid, bus_rst, glitch, frame_err, overrun}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic word
        send_bits(8'hA5, 8, 10, 40);
        check_counts("basic");

        // Glitch mid-word, then boundary widths
        send_bits(8'hA5, 4, 10, 40);
        send_pulse(3, 30);
        send_bits(8'hA5 >> 4, 4, 10, 40);
        send_bits(8'h96, 8, TMIN, TTHR);
        send_bits(8'h69, 8, TTHR - 1, TRST - 1);
        check_counts("glitch_bound");

        // Bus reset after 3 bits, exact-threshold reset, then a clean word
        send_bits(8'h07, 3, 10, 40);
        send_pulse(150, 30);
        send_pulse(TRST, 30);
        send_bits(8'h3C, 8, 10, 40);
        check_counts("bus_reset");

        // Partial word timeout
        send_bits(8'h1B, 4, 10, 40);
        send_pulse(40, 250);
        send_bits(8'h81, 8, 10, 40);
        check_counts("timeout");

        // Backpressure and overrun
        rx_ready = 1'b0;
        send_bits(8'h11, 8, 10, 40);
        send_bits(8'h22, 8, 10, 40);
        repeat (5) @(negedge clk);
        check("bp_rx_valid", rx_valid, 1);
        check("bp_rx_data", rx_data, 8'h11);
        rx_ready = 1'b1;
        held     = 1'b0;
        repeat (2) @(negedge clk);
        check("bp_valid_cleared", rx_valid, 0);
        check_counts("backpressure");

        // Async reset with a word pending and a partial word in flight
        rx_ready = 1'b0;
        send_bits(8'h77, 8, 10, 40);
        send_bits(8'h0F, 4, 10, 40);
        #3 rst_n = 1'b0;
        #1 check("async_reset_outputs", {rx_data, rx_valid, bus_rst, glitch, frame_err, overrun}, 0);
        exp_q.delete();
        bus_q.delete();
        nbits    = 0;
        held     = 1'b0;
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_bits(8'h5A, 8, 10, 40);
        check_counts("async_reset");

        // Randomized traffic
        for (int k = 0; k < 25; k++) begin
            logic [DW-1:0] v;
            v = DW'($urandom);
            for (int unsigned i = 0; i < DW; i++) begin
                logic [DW-1:0] t;
                t = v >> i;
                if ($urandom_range(0, 7) == 0) send_pulse($urandom_range(1, TMIN - 1), $urandom_range(2, 60));
                if ($urandom_range(0, 39) == 0) send_pulse($urandom_range(TRST, TRST + 30), $urandom_range(2, 60));
                if (t[0]) send_pulse($urandom_range(TMIN, TTHR - 1), $urandom_range(2, 60));
                else      send_pulse($urandom_range(TTHR, TRST - 1), $urandom_range(2, 60));
            end
        end
        check_counts("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
